beep_scheduler: RTL

//  Owns the single piezo 'beep' output and shares it between four sound requesters.

---
 rtl/beep_scheduler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/beep_scheduler.sv
// rtl/beep_scheduler.sv - shares one piezo beep output between four prioritized sound requesters.
// Latches request pulses, grants the highest pending sound, and plays its 4-note pattern.
module beep_scheduler #(
    parameter int NOTE_TICKS = 5_000_000,
    parameter int HP_SHIFT   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] gamemode,
    input  logic [3:0] req,
    output logic       beep,
    output logic [3:0] grant,
    output logic       busy,
    output logic       done
);

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    localparam logic [22:0] NOTE_LAST = 23'(NOTE_TICKS - 1);
    localparam logic [16:0] HP_A4 = 17'd113636;
    localparam logic [16:0] HP_C5 = 17'd95556;
    localparam logic [16:0] HP_E5 = 17'd75843;
    localparam logic [16:0] HP_G5 = 17'd63776;
    localparam logic [16:0] HP_C6 = 17'd47778;
    localparam logic [16:0] HP_R  = 17'd0;

    function automatic logic [16:0] rom_hp(input logic [3:0] g, input logic [1:0] idx);
        logic [16:0] hp;
        hp = HP_R;
        case (g)
            4'b0001: hp = (idx == 2'd0) ? HP_C6 : HP_R;
            4'b0010: hp = idx[0] ? HP_R : HP_A4;
            4'b0100: begin
                case (idx)
                    2'd0:    hp = HP_C5;
                    2'd1:    hp = HP_E5;
                    2'd2:    hp = HP_G5;
                    default: hp = HP_C6;
                endcase
            end
            4'b1000: begin
                case (idx)
                    2'd0:    hp = HP_G5;
                    2'd1:    hp = HP_E5;
                    2'd2:    hp = HP_C5;
                    default: hp = HP_A4;
                endcase
            end
            default: hp = HP_R;
        endcase
        return hp >> HP_SHIFT;
    endfunction

    function automatic logic [3:0] highest(input logic [3:0] p);
        logic [3:0] h;
        h = 4'b0000;
        if (p[3])      h = 4'b1000;
        else if (p[2]) h = 4'b0100;
        else if (p[1]) h = 4'b0010;
        else if (p[0]) h = 4'b0001;
        return h;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  pend_q, pend_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  note_idx_q, note_idx_d;
    logic [22:0] note_cnt_q, note_cnt_d;
    logic [16:0] tone_cnt_q, tone_cnt_d;
    logic        phase_q, phase_d;
    logic        beep_q, beep_d;
    logic        done_q, done_d;

    logic        paused;
    logic [16:0] hp;
    logic [3:0]  above;
    logic [3:0]  clr;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        note_idx_d = note_idx_q;
        note_cnt_d = note_cnt_q;
        tone_cnt_d = tone_cnt_q;
        phase_d    = phase_q;
        beep_d     = 1'b0;
        done_d     = 1'b0;
        clr        = 4'b0000;

        paused = (gamemode == 2'b10);
        hp     = rom_hp(grant_q, note_idx_q);
        // Pending bits strictly above the current grant may preempt it.
        above  = pend_q & ~(grant_q | (grant_q - 4'd1));

        case (state_q)
            S_IDLE: begin
                if (!paused && pend_q != 4'b0000) begin
                    grant_d    = highest(pend_q);
                    clr        = grant_d;
                    state_d    = S_PLAY;
                    note_idx_d = 2'd0;
                    note_cnt_d = '0;
                    tone_cnt_d = '0;
                    phase_d    = 1'b0;
                end
            end
            default: begin
                if (paused) begin
                    beep_d = 1'b0;
                end else if (above != 4'b0000) begin
                    grant_d    = highest(above);
                    clr        = grant_d;
                    note_idx_d = 2'd0;
                    note_cnt_d = '0;
                    tone_cnt_d = '0;
                    phase_d    = 1'b0;
                end else if (note_cnt_q == NOTE_LAST) begin
                    note_cnt_d = '0;
                    tone_cnt_d = '0;
                    phase_d    = 1'b0;
                    if (note_idx_q == 2'd3) begin
                        state_d = S_IDLE;
                        grant_d = 4'b0000;
                        done_d  = 1'b1;
                    end else begin
                        note_idx_d = note_idx_q + 2'd1;
                    end
                end else begin
                    note_cnt_d = note_cnt_q + 23'd1;
                    if (hp == 17'd0) begin
                        tone_cnt_d = '0;
                        phase_d    = 1'b0;
                    end else if (tone_cnt_q == hp - 17'd1) begin
                        tone_cnt_d = '0;
                        phase_d    = ~phase_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + 17'd1;
                    end
                    beep_d = phase_d;
                end
            end
        endcase

        // A request arriving on the grant edge survives the clear, queueing a replay.
        pend_d = (pend_q & ~clr) | req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pend_q     <= 4'b0000;
            grant_q    <= 4'b0000;
            note_idx_q <= 2'd0;
            note_cnt_q <= '0;
            tone_cnt_q <= '0;
            phase_q    <= 1'b0;
            beep_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            grant_q    <= grant_d;
            note_idx_q <= note_idx_d;
            note_cnt_q <= note_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            phase_q    <= phase_d;
            beep_q     <= beep_d;
            done_q     <= done_d;
        end
    end

    assign beep  = beep_q;
    assign grant = grant_q;
    assign busy  = (state_q == S_PLAY);
    assign done  = done_q;

endmodule
